// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised inter-stage pipeline register with flush, valid, bubble marker and saturating hold counter
//   clk, rst       : clock, synchronous active-high reset
//   stall, flush   : Ctrl stall vector (stall[STAGE] upstream, stall[STAGE+1] downstream), flush line
//   valid_i/data_i/side_i : upstream valid, bubbled payload, sideband
//   valid_o/data_o/side_o : registered valid, payload, sideband
//   bubble_o       : contents came from reset, bubble or flush
//   hold_cnt_o     : consecutive hold cycles, saturating
module pipe_stage_reg #(
    parameter int                DATA_W      = 140,
    parameter int                SIDE_W      = 32,
    parameter int                STALL_W     = 6,
    parameter int                STAGE       = 2,
    parameter int                CNT_W       = 8,
    parameter logic [DATA_W-1:0] BUBBLE_DATA = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic               valid_i,
    input  logic [DATA_W-1:0]  data_i,
    input  logic [SIDE_W-1:0]  side_i,
    output logic               valid_o,
    output logic [DATA_W-1:0]  data_o,
    output logic [SIDE_W-1:0]  side_o,
    output logic               bubble_o,
    output logic [CNT_W-1:0]   hold_cnt_o
);
    logic              w_s_up, w_s_dn;
    logic              r_valid, r_bubble;
    logic [DATA_W-1:0] r_data;
    logic [SIDE_W-1:0] r_side;
    logic [CNT_W-1:0]  r_hold_cnt;
    assign w_s_up = stall[STAGE];
    assign w_s_dn = stall[STAGE+1];
    // Sideband is captured on reset and bubble so an exception raised in a stalled stage still propagates.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid    <= 1'b0;
            r_data     <= BUBBLE_DATA;
            r_side     <= side_i;
            r_bubble   <= 1'b1;
            r_hold_cnt <= '0;
        end else if (flush) begin
            r_valid    <= 1'b0;
            r_data     <= BUBBLE_DATA;
            r_side     <= '0;
            r_bubble   <= 1'b1;
            r_hold_cnt <= '0;
        end else if (w_s_dn) begin
            r_hold_cnt <= &r_hold_cnt ? r_hold_cnt : r_hold_cnt + CNT_W'(1);
        end else if (w_s_up) begin
            r_valid    <= 1'b0;
            r_data     <= BUBBLE_DATA;
            r_side     <= side_i;
            r_bubble   <= 1'b1;
            r_hold_cnt <= '0;
        end else begin
            r_valid    <= valid_i;
            r_data     <= data_i;
            r_side     <= side_i;
            r_bubble   <= 1'b0;
            r_hold_cnt <= '0;
        end
    end
    assign valid_o    = r_valid;
    assign data_o     = r_data;
    assign side_o     = r_side;
    assign bubble_o   = r_bubble;
    assign hold_cnt_o = r_hold_cnt;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed test-plan scenarios plus randomized stimulus against a behavioural model
module tb_pipe_stage_reg;
    localparam int DW = 140;
    localparam int SW = 32;
    localparam int CW = 3;
    localparam logic [DW-1:0] BUB = 140'h5A5A_0F0F;
    logic          clk = 1'b0;
    logic          rst, flush, valid_i;
    logic [5:0]    stall;
    logic [DW-1:0] data_i, data_o;
    logic [SW-1:0] side_i, side_o;
    logic          valid_o, bubble_o;
    logic [CW-1:0] hold_cnt_o;
    int n_vec = 0;
    int n_bad = 0;
    logic          e_valid, e_bubble;
    logic [DW-1:0] e_data;
    logic [SW-1:0] e_side;
    int            e_cnt;

    pipe_stage_reg #(.DATA_W(DW), .SIDE_W(SW), .STALL_W(6), .STAGE(2), .CNT_W(CW), .BUBBLE_DATA(BUB)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_i(valid_i),
        .data_i(data_i), .side_i(side_i), .valid_o(valid_o), .data_o(data_o),
        .side_o(side_o), .bubble_o(bubble_o), .hold_cnt_o(hold_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic r, input logic f, input logic [5:0] st, input logic v,
                         input logic [DW-1:0] d, input logic [SW-1:0] s);
        rst = r; flush = f; stall = st; valid_i = v; data_i = d; side_i = s;
    endtask

    // Model: predict the stage contents from the inputs seen at the coming edge, then compare.
    task automatic step();
        bit up, dn;
        up = stall[2];
        dn = stall[3];
        if (rst || flush || (up && !dn)) begin
            e_valid = 1'b0; e_data = BUB; e_bubble = 1'b1; e_cnt = 0;
            e_side = flush && !rst ? '0 : side_i;
        end else if (dn) begin
            e_cnt = e_cnt + 1 > (1 << CW) - 1 ? (1 << CW) - 1 : e_cnt + 1;
        end else begin
            e_valid = valid_i; e_data = data_i; e_side = side_i; e_bubble = 1'b0; e_cnt = 0;
        end
        @(posedge clk);
        #1;
        chk("valid", 160'(valid_o), 160'(e_valid));
        chk("data", 160'(data_o), 160'(e_data));
        chk("side", 160'(side_o), 160'(e_side));
        chk("bubble", 160'(bubble_o), 160'(e_bubble));
        chk("hold_cnt", 160'(hold_cnt_o), 160'(e_cnt));
    endtask

    initial begin
        drive(1, 0, 6'b0, 0, '0, 32'h1234);
        step();
        chk("rst_data", 160'(data_o), 160'(BUB));
        chk("rst_side", 160'(side_o), 160'h1234);
        // straight advance
        drive(0, 0, 6'b0, 1, 140'hA, 32'h1);
        step();
        chk("adv_A", 160'(data_o), 160'hA);
        drive(0, 0, 6'b0, 1, 140'hB, 32'h2);
        step();
        chk("adv_B", 160'(data_o), 160'hB);
        drive(0, 0, 6'b0, 1, 140'hC, 32'h3);
        step();
        chk("adv_C", 160'(data_o), 160'hC);
        // bubble
        drive(0, 0, 6'b000100, 1, 140'h55, 32'h200);
        step();
        chk("bub_bubble", 160'(bubble_o), 160'h1);
        chk("bub_side", 160'(side_o), 160'h200);
        drive(0, 0, 6'b0, 1, 140'h55, 32'h200);
        step();
        chk("after_bub", 160'(data_o), 160'h55);
        // hold and saturation
        drive(0, 0, 6'b0, 1, 140'hABCD, 32'h9);
        step();
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 6'b001100, 1, 140'(i + 1), 32'(i));
            step();
            chk("hold_data", 160'(data_o), 160'hABCD);
            chk("hold_seq", 160'(hold_cnt_o), 160'(i < 7 ? i + 1 : 7));
        end
        drive(0, 0, 6'b0, 1, 140'h99, 32'h9);
        step();
        chk("release_cnt", 160'(hold_cnt_o), 160'h0);
        // flush vs stall
        drive(0, 1, 6'b001100, 1, 140'h33, 32'hFF);
        step();
        chk("flush_side", 160'(side_o), 160'h0);
        // reset mid-hold
        drive(0, 0, 6'b0, 1, 140'h44, 32'h4);
        step();
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 6'b001100, 1, 140'h0, 32'h0);
            step();
        end
        chk("pre_rst_cnt", 160'(hold_cnt_o), 160'h4);
        drive(1, 0, 6'b001100, 1, 140'h0, 32'h10);
        step();
        chk("midhold_rst_side", 160'(side_o), 160'h10);
        drive(0, 0, 6'b0, 1, 140'h66, 32'h6);
        step();
        chk("post_rst_adv", 160'(data_o), 160'h66);
        // upstream-empty slot
        drive(0, 0, 6'b0, 0, 140'h77, 32'h7);
        step();
        chk("empty_bubble", 160'(bubble_o), 160'h0);
        chk("empty_data", 160'(data_o), 160'h77);
        // randomized
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 31) == 0, $urandom_range(0, 15) == 0, 6'($urandom),
                  1'($urandom), {12'($urandom), {4{32'($urandom)}}}, 32'($urandom));
            step();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
